// File: rtl/mem_responder_if.sv
// Cache-to-memory request interface: the initiator (master) drives one
// single-word beat at a time, and the responder (slave) completes it.
interface mem_responder_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_ready;
  logic                  mem_err;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready, mem_err
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready, mem_err
  );
endinterface

// File: rtl/mem_responder.sv
// Word-addressed backing memory that responds to single-word beats after a
// programmable access latency. Optional feature macro MEM_RESP_BURST_EN:
// beats continuing a sequential run within one cache line complete with
// latency 1.
module mem_responder #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_WORDS  = 4096,
  parameter int LATENCY    = 4,
  parameter int LINE_BYTES = 64
) (
  input  logic           clk,
  input  logic           rst,
  mem_responder_if.slave bus
);

  localparam int WORD_BYTES = DATA_WIDTH / 8;
  localparam int OFF_BITS   = $clog2(WORD_BYTES);
  localparam int IDX_BITS   = $clog2(MEM_WORDS);
  localparam int CNT_W      = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = (LATENCY >= 2) ? CNT_W'(LATENCY - 2) : '0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  state_t                state, state_d;
  logic [CNT_W-1:0]      cnt, cnt_d;
  logic [IDX_BITS-1:0]   cap_idx;
  logic                  cap_we;
  logic                  cap_err;
  logic [DATA_WIDTH-1:0] cap_wdata;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  logic                  capture;
  logic                  abort;
  logic                  lat_one;
  logic                  enter_ack;
  logic [IDX_BITS-1:0]   live_idx;
  logic [IDX_BITS-1:0]   rd_idx;

  assign live_idx = bus.mem_addr[OFF_BITS +: IDX_BITS];

`ifdef MEM_RESP_BURST_EN
  localparam int WA = ADDR_WIDTH - OFF_BITS;
  localparam int LW = $clog2(LINE_BYTES) - OFF_BITS;

  logic          hist_valid;
  logic          hist_we;
  logic [WA-1:0] hist_word;
  logic [WA-1:0] cap_word;
  logic [WA-1:0] cur_word;
  logic          seq;

  assign cur_word = bus.mem_addr[ADDR_WIDTH-1:OFF_BITS];
  assign seq = hist_valid && (bus.mem_we == hist_we) &&
               (cur_word == hist_word + WA'(1)) &&
               (cur_word[WA-1:LW] == hist_word[WA-1:LW]);
  assign lat_one = seq || (LATENCY == 1);

  // History of the last completed beat; dropped on reset or abort.
  always_ff @(posedge clk) begin
    if (rst || abort) begin
      hist_valid <= 1'b0;
      hist_we    <= 1'b0;
      hist_word  <= '0;
    end else if (state == S_ACK) begin
      hist_valid <= 1'b1;
      hist_we    <= cap_we;
      hist_word  <= cap_word;
    end
  end

  // Word address of the captured beat, recorded into history on completion.
  always_ff @(posedge clk) begin
    if (rst) cap_word <= '0;
    else if (capture) cap_word <= cur_word;
  end
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^bus.mem_addr;
  assign lat_one = (LATENCY == 1);
`endif

  // Next-state logic: capture in idle, count down in wait, one-cycle ack.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    capture = 1'b0;
    abort   = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.mem_req) begin
          capture = 1'b1;
          if (lat_one) begin
            state_d = S_ACK;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (!bus.mem_req) begin
          abort   = 1'b1;
          state_d = S_IDLE;
        end else if (cnt == '0) begin
          state_d = S_ACK;
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // On a direct idle->ack transition the beat is not captured yet, so the
  // read index comes from the live address.
  assign enter_ack = (state_d == S_ACK) && (state != S_ACK);
  assign rd_idx    = (state == S_IDLE) ? live_idx : cap_idx;

  // State, counter, captured beat and registered read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      cap_idx   <= '0;
      cap_we    <= 1'b0;
      cap_err   <= 1'b0;
      cap_wdata <= '0;
      rdata_q   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      if (capture) begin
        cap_idx   <= live_idx;
        cap_we    <= bus.mem_we;
        cap_err   <= |bus.mem_addr[OFF_BITS-1:0];
        cap_wdata <= bus.mem_wdata;
      end
      if (enter_ack) rdata_q <= mem[rd_idx];
    end
  end

  // Array write at the edge closing the ack cycle; reset cancels it.
  always_ff @(posedge clk) begin
    if (!rst && state == S_ACK && cap_we) mem[cap_idx] <= cap_wdata;
  end

  assign bus.mem_ready = (state == S_ACK);
  assign bus.mem_err   = (state == S_ACK) && cap_err;
  assign bus.mem_rdata = rdata_q;

endmodule
